// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB bridge arbiter.
//   arb_state_t : sequencer FSM states (IDLE, SETUP, ACCESS, RESP)
//   idx_w()     : width of an index able to address n items (minimum 1 bit)
//   ERR_FILL    : fill bit for the read data returned on writes and aborts
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Error / write responses return all-zero read data.
  localparam logic ERR_FILL = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i        : request vector, one bit per requester
//   last_grant_i : index of the most recently granted requester
//   idx_o        : winning index (first requester at or after last_grant_i+1)
//   vld_o        : high when any request is present
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [idx_w(NUM_REQ)-1:0]       last_grant_i,
  output logic [idx_w(NUM_REQ)-1:0]       idx_o,
  output logic                            vld_o
);

  localparam int IDX_W = idx_w(NUM_REQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant_i is the final assignment and therefore the winner.
  always_comb begin
    idx_o    = '0;
    vld_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(last_grant_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        idx_o = cand_idx;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter and APB sequencer sharing the bridge A-side port
// between NUM_REQ local requesters. One transfer in flight at a time.
//   clk, rst_n            : A-domain clock, synchronous active-low reset
//   req_psel/pwrite       : per-requester select / direction
//   req_paddr/pwdata      : packed per-requester payload, slot i at [i*W +: W]
//   req_prdata            : shared read data, valid with any req_pready bit
//   req_pready/pslverr    : one-hot completion pulse / error qualifier
//   m_psel..m_pwdata      : APB master outputs toward the bridge
//   m_prdata, m_pready    : APB responses from the bridge
//   grant_id              : index of current or last owner
//   busy                  : high whenever the sequencer is not idle
// All outputs come straight from registers.
module apb_bridge_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_psel,
  input  logic [NUM_REQ-1:0]          req_pwrite,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_paddr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_pwdata,
  output logic [DATA_W-1:0]           req_prdata,
  output logic [NUM_REQ-1:0]          req_pready,
  output logic [NUM_REQ-1:0]          req_pslverr,
  output logic                        m_psel,
  output logic                        m_penable,
  output logic                        m_pwrite,
  output logic [ADDR_W-1:0]           m_paddr,
  output logic [DATA_W-1:0]           m_pwdata,
  input  logic [DATA_W-1:0]           m_prdata,
  input  logic                        m_pready,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(TIMEOUT + 1);
  // Counter value during the last permitted ACCESS cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [DATA_W-1:0]  ERR_DATA = {DATA_W{ERR_FILL}};

  arb_state_t          state_q;
  logic [IDX_W-1:0]    grant_id_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]    tmo_q;
  logic                busy_q;
  logic                m_psel_q;
  logic                m_penable_q;
  logic                m_pwrite_q;
  logic [ADDR_W-1:0]   m_paddr_q;
  logic [DATA_W-1:0]   m_pwdata_q;
  logic [DATA_W-1:0]   req_prdata_q;
  logic [NUM_REQ-1:0]  req_pready_q;
  logic [NUM_REQ-1:0]  req_pslverr_q;

  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic [NUM_REQ-1:0]  gnt_oh;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_paddr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_pwdata[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i        (req_psel),
    .last_grant_i (last_grant_q),
    .idx_o        (win_idx),
    .vld_o        (win_vld)
  );

  assign gnt_oh = ONE_HOT0 << grant_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      m_psel_q      <= 1'b0;
      m_penable_q   <= 1'b0;
      m_pwrite_q    <= 1'b0;
      m_paddr_q     <= '0;
      m_pwdata_q    <= '0;
      req_prdata_q  <= '0;
      req_pready_q  <= '0;
      req_pslverr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            grant_id_q   <= win_idx;
            last_grant_q <= win_idx;
            m_paddr_q    <= addr_a[win_idx];
            m_pwdata_q   <= wdata_a[win_idx];
            m_pwrite_q   <= req_pwrite[win_idx];
            m_psel_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          m_penable_q <= 1'b1;
          tmo_q       <= '0;
          state_q     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Ready in the final permitted cycle takes precedence over abort.
          if (m_pready) begin
            req_prdata_q  <= m_pwrite_q ? ERR_DATA : m_prdata;
            req_pready_q  <= gnt_oh;
            req_pslverr_q <= '0;
            m_psel_q      <= 1'b0;
            m_penable_q   <= 1'b0;
            state_q       <= ST_RESP;
          end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
            req_prdata_q  <= ERR_DATA;
            req_pready_q  <= gnt_oh;
            req_pslverr_q <= gnt_oh;
            m_psel_q      <= 1'b0;
            m_penable_q   <= 1'b0;
            state_q       <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RESP: begin
          req_pready_q  <= '0;
          req_pslverr_q <= '0;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_prdata  = req_prdata_q;
  assign req_pready  = req_pready_q;
  assign req_pslverr = req_pslverr_q;
  assign m_psel      = m_psel_q;
  assign m_penable   = m_penable_q;
  assign m_pwrite    = m_pwrite_q;
  assign m_paddr     = m_paddr_q;
  assign m_pwdata    = m_pwdata_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
module tb_apb_bridge_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_REQ-1:0]          req_psel;
  logic [NUM_REQ-1:0]          req_pwrite;
  logic [NUM_REQ*ADDR_W-1:0]   req_paddr;
  logic [NUM_REQ*DATA_W-1:0]   req_pwdata;
  logic [DATA_W-1:0]           req_prdata;
  logic [NUM_REQ-1:0]          req_pready;
  logic [NUM_REQ-1:0]          req_pslverr;
  logic                        m_psel;
  logic                        m_penable;
  logic                        m_pwrite;
  logic [ADDR_W-1:0]           m_paddr;
  logic [DATA_W-1:0]           m_pwdata;
  logic [DATA_W-1:0]           m_prdata;
  logic                        m_pready;
  logic [1:0]                  grant_id;
  logic                        busy;

  int n_cmp = 0;
  int n_err = 0;

  apb_bridge_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_psel    (req_psel),
    .req_pwrite  (req_pwrite),
    .req_paddr   (req_paddr),
    .req_pwdata  (req_pwdata),
    .req_prdata  (req_prdata),
    .req_pready  (req_pready),
    .req_pslverr (req_pslverr),
    .m_psel      (m_psel),
    .m_penable   (m_penable),
    .m_pwrite    (m_pwrite),
    .m_paddr     (m_paddr),
    .m_pwdata    (m_pwdata),
    .m_prdata    (m_prdata),
    .m_pready    (m_pready),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then show the new state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_psel   = '0;
    req_pwrite = '0;
    req_paddr  = '0;
    req_pwdata = '0;
    m_prdata   = '0;
    m_pready   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_paddr[i*ADDR_W +: ADDR_W]  = 32'h0000_0100 * (i + 1);
      req_pwdata[i*DATA_W +: DATA_W] = 32'h1111_0000 + i;
    end
    tick();
    tick();

    // Reset state
    chk("rst_psel",    m_psel,      0);
    chk("rst_penable", m_penable,   0);
    chk("rst_paddr",   m_paddr,     0);
    chk("rst_pready",  req_pready,  0);
    chk("rst_pslverr", req_pslverr, 0);
    chk("rst_prdata",  req_prdata,  0);
    chk("rst_grant",   grant_id,    0);
    chk("rst_busy",    busy,        0);

    // Single zero-wait read from requester 1
    rst_n    = 1'b1;
    req_paddr[1*ADDR_W +: ADDR_W] = 32'h0000_1000;
    req_psel = 4'b0010;
    m_pready = 1'b1;
    m_prdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_setup_psel",    m_psel,    1);
    chk("rd_setup_penable", m_penable, 0);
    chk("rd_setup_addr",    m_paddr,   32'h0000_1000);
    chk("rd_setup_grant",   grant_id,  1);
    chk("rd_setup_busy",    busy,      1);
    chk("rd_setup_pready",  req_pready, 0);
    tick();
    chk("rd_acc_psel",    m_psel,     1);
    chk("rd_acc_penable", m_penable,  1);
    chk("rd_acc_pready",  req_pready, 0);
    tick();
    chk("rd_resp_pready",  req_pready,  4'b0010);
    chk("rd_resp_prdata",  req_prdata,  32'hDEAD_BEEF);
    chk("rd_resp_pslverr", req_pslverr, 0);
    chk("rd_resp_psel",    m_psel,      0);
    req_psel = '0;
    tick();
    chk("rd_idle_pready", req_pready, 0);
    chk("rd_idle_busy",   busy,       0);

    // Fairness from reset: all four request continuously
    rst_n = 1'b0;
    req_paddr[1*ADDR_W +: ADDR_W] = 32'h0000_0200;
    tick();
    rst_n    = 1'b1;
    req_psel = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", grant_id, k % 4);
      chk("rr_addr",  m_paddr,  32'h0000_0100 * ((k % 4) + 1));
      m_prdata = 32'hA500_0000 + k;
      tick();
      chk("rr_penable", m_penable, 1);
      tick();
      chk("rr_pready", req_pready, 64'd1 << (k % 4));
      chk("rr_prdata", req_prdata, 32'hA500_0000 + k);
      tick();
      chk("rr_idle_pready", req_pready, 0);
    end
    req_psel = '0;

    // Write from requester 2 with five wait states
    m_pready = 1'b0;
    req_pwrite[2] = 1'b1;
    req_pwdata[2*DATA_W +: DATA_W] = 32'hCAFE_F00D;
    req_paddr[2*ADDR_W +: ADDR_W]  = 32'h0000_2000;
    req_psel = 4'b0100;
    tick();
    chk("wr_setup_grant", grant_id, 2);
    chk("wr_setup_write", m_pwrite, 1);
    chk("wr_setup_addr",  m_paddr,  32'h0000_2000);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("wr_acc_penable", m_penable,  1);
      chk("wr_acc_pwdata",  m_pwdata,   32'hCAFE_F00D);
      chk("wr_acc_pready",  req_pready, 0);
      if (j == 6) m_pready = 1'b1;
    end
    tick();
    chk("wr_resp_pready",  req_pready,  4'b0100);
    chk("wr_resp_pslverr", req_pslverr, 0);
    chk("wr_resp_prdata",  req_prdata,  0);
    chk("wr_resp_psel",    m_psel,      0);
    req_psel = '0;
    req_pwrite[2] = 1'b0;
    tick();
    chk("wr_idle_pready", req_pready, 0);

    // Timeout abort: requester 3, bridge never ready
    m_pready = 1'b0;
    m_prdata = 32'h1234_5678;
    req_psel = 4'b1000;
    tick();
    chk("to_setup_grant", grant_id, 3);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("to_acc_psel",    m_psel,     1);
      chk("to_acc_penable", m_penable,  1);
      chk("to_acc_pready",  req_pready, 0);
    end
    tick();
    chk("to_resp_psel",    m_psel,      0);
    chk("to_resp_penable", m_penable,   0);
    chk("to_resp_pready",  req_pready,  4'b1000);
    chk("to_resp_pslverr", req_pslverr, 4'b1000);
    chk("to_resp_prdata",  req_prdata,  0);
    req_psel = '0;
    tick();
    chk("to_idle_pslverr", req_pslverr, 0);

    // Ready in the last permitted ACCESS cycle completes normally
    req_psel = 4'b0001;
    tick();
    chk("tr_setup_grant", grant_id, 0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("tr_acc_penable", m_penable, 1);
      if (j == 8) m_pready = 1'b1;
    end
    tick();
    chk("tr_resp_pready",  req_pready,  4'b0001);
    chk("tr_resp_pslverr", req_pslverr, 0);
    chk("tr_resp_prdata",  req_prdata,  32'h1234_5678);
    req_psel = '0;
    m_pready = 1'b0;
    tick();

    // Reset during ACCESS, then requester 0 wins first
    req_psel = 4'b1111;
    tick();
    chk("ra_setup_grant", grant_id, 1);
    tick();
    chk("ra_acc_penable", m_penable, 1);
    rst_n = 1'b0;
    tick();
    chk("ra_rst_psel",    m_psel,     0);
    chk("ra_rst_penable", m_penable,  0);
    chk("ra_rst_pready",  req_pready, 0);
    chk("ra_rst_busy",    busy,       0);
    chk("ra_rst_grant",   grant_id,   0);
    chk("ra_rst_paddr",   m_paddr,    0);
    rst_n = 1'b1;
    tick();
    chk("ra_post_grant", grant_id, 0);
    chk("ra_post_addr",  m_paddr,  32'h0000_0100);
    chk("ra_post_psel",  m_psel,   1);
    m_pready = 1'b1;
    m_prdata = 32'h0000_0042;
    tick();
    tick();
    chk("ra_post_pready", req_pready, 4'b0001);
    chk("ra_post_prdata", req_prdata, 32'h0000_0042);
    req_psel = '0;
    tick();

    // Requester 3 drops psel right after grant; transfer still completes
    m_prdata = 32'h0000_3333;
    req_psel = 4'b1000;
    tick();
    chk("dr_setup_grant", grant_id, 3);
    req_psel = '0;
    tick();
    chk("dr_acc_penable", m_penable, 1);
    tick();
    chk("dr_resp_pready", req_pready, 4'b1000);
    chk("dr_resp_prdata", req_prdata, 32'h0000_3333);
    tick();
    chk("dr_idle_busy",   busy,       0);
    chk("dr_idle_pready", req_pready, 0);
    tick();
    chk("dr_stay_idle_psel", m_psel, 0);
    chk("dr_stay_idle_busy", busy,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_bridge_arbiter.md
# apb_bridge_arbiter

Round-robin arbiter and APB sequencer that shares the single A-side APB port of the async APB bridge between `NUM_REQ` local APB requesters. Accepts one transfer at a time, drives a protocol-correct SETUP/ACCESS sequence into the bridge, returns read data and a completion pulse to the granted requester, and aborts transfers that stall beyond a programmable timeout. Lives entirely in the bridge's A clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `TIMEOUT`, 255: max ACCESS cycles before abort; 0 disables timeout

- `clk`  in  1  A-domain clock; single clock for the whole block
- `rst_n`  in  1  synchronous, active-low reset
- `req_psel`  in  NUM_REQ  per-requester select
- `req_pwrite`  in  NUM_REQ  per-requester direction
- `req_paddr`  in  NUM_REQ*ADDR_W  packed, requester i at `[i*ADDR_W +: ADDR_W]`
- `req_pwdata`  in  NUM_REQ*DATA_W  packed, same layout
- `req_prdata`  out  DATA_W  shared read data, valid when any `req_pready` bit is high
- `req_pready`  out  NUM_REQ  one-hot completion pulse
- `req_pslverr`  out  NUM_REQ  one-hot error, qualifies `req_pready`
- `m_psel`, `m_penable`, `m_pwrite`  out  1  to bridge A side
- `m_paddr`  out  ADDR_W;  `m_pwdata`  out  DATA_W
- `m_prdata`  in  DATA_W;  `m_pready`  in  1  from bridge A side
- `grant_id`  out  $clog2(NUM_REQ)  index of current or last owner
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any `req_psel` is high, pick the winner by round-robin starting at `last_grant+1` (wrapping modulo NUM_REQ). Latch its addr/wdata/write into `m_*` registers, set `grant_id`, update `last_grant`, go to SETUP.
- SETUP: `m_psel`=1, `m_penable`=0, held for exactly one cycle. Go to ACCESS.
- ACCESS: `m_psel`=1, `m_penable`=1. On `m_pready`: capture `m_prdata` (reads only; writes capture 0), clear `m_psel`/`m_penable`, go to RESP. If `TIMEOUT`≠0 and the timeout counter reaches `TIMEOUT` without `m_pready`: clear `m_psel`/`m_penable`, set error, capture 0, go to RESP.
- RESP: `req_pready[grant_id]`=1 and `req_pslverr[grant_id]`=error for one cycle; all other bits 0. Go to IDLE.
- Requester protocol: hold psel and payload until its `req_pready` pulse, then drop or start a new transfer. A requester that drops psel after grant does not cancel; the committed transfer completes and still pulses `req_pready`.
- `m_pready` in SETUP or IDLE is ignored.
- Fairness: with all requesters continuously requesting, each is served once per NUM_REQ transfers.

## Timing
- Reset (`rst_n`=0 at a `clk` edge): state=IDLE, all `m_*` outputs 0, `req_pready`/`req_pslverr`/`req_prdata` 0, `grant_id`=0, `busy`=0, timeout counter 0, `last_grant`=NUM_REQ-1, so requester 0 has top priority first. Reset mid-transfer drops `m_psel` the next cycle without a response pulse.
- Latency, zero-wait bridge: psel sampled at edge 0, SETUP at cycle 1, ACCESS at cycle 2, `req_pready` at cycle 3, next grant possible at cycle 4. Minimum 4 cycles per transfer.
- Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle. Abort occurs in ACCESS cycle `TIMEOUT`. `m_pready` in that same cycle wins: normal completion, no error.
- All outputs are registered. No combinational path from `req_*` or `m_pready` to any output.

## Structure
- Package `apb_arb_pkg`: FSM state enum `arb_state_t`, `IDX_W` helper function, and the error-response data constant (0).
- Sub-module `rr_arbiter`: combinational masked priority pick. Inputs are the request vector and `last_grant`; outputs are the winner index and a valid flag. Reused elsewhere.

## Test plan
- Single read, req1 addr 0x1000, bridge zero-wait `m_prdata`=0xDEADBEEF -> `m_psel` rises cycle 1, `m_penable` cycle 2, `req_pready`=0b0010 and `req_prdata`=0xDEADBEEF at cycle 3.
- All four requesters request continuously from reset -> grants in order 0,1,2,3,0, one transfer per 4 cycles.
- Write from req2 with bridge holding `m_pready` low 5 cycles -> ACCESS lasts 6 cycles, `m_pwdata` stable throughout, `req_pready[2]` pulses once, `req_pslverr`=0.
- `TIMEOUT`=8, bridge never ready -> `m_psel` drops after ACCESS cycle 8, `req_pslverr[k]`=`req_pready[k]`=1, `req_prdata`=0. Repeat with `m_pready` in cycle 8 -> no error.
- Assert `rst_n`=0 during ACCESS -> next cycle all outputs 0, no `req_pready`. After release, req0 (if requesting) wins first.
- req3 drops psel one cycle after grant -> transfer still completes and `req_pready[3]` pulses.
